// File: rtl/ahb_apb_bridge_core.sv
// AHB-to-APB2 bridge: converts single AHB transfers into APB SETUP/ENABLE accesses
// across NUM_SLV address-decoded slaves, with AHB wait states and OKAY/ERROR responses.
module ahb_apb_bridge_core #(
  parameter int unsigned        ADDR_W       = 32,
  parameter int unsigned        DATA_W       = 32,
  parameter int unsigned        NUM_SLV      = 3,
  parameter logic [ADDR_W-1:0]  BASE_ADDR    = 32'h8000_0000,
  parameter int unsigned        REGION_SHIFT = 26
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [1:0]         htrans,
  input  logic               hwrite,
  input  logic               hreadyin,
  input  logic [ADDR_W-1:0]  haddr,
  input  logic [2:0]         hburst,
  input  logic [DATA_W-1:0]  hwdata,
  input  logic [2:0]         hsize,
  output logic               hreadyout,
  output logic [1:0]         hresp,
  output logic [DATA_W-1:0]  hrdata,
  output logic [ADDR_W-1:0]  paddr,
  output logic [DATA_W-1:0]  pwdata,
  output logic               pwrite,
  output logic [NUM_SLV-1:0] pselx,
  output logic               penable,
  input  logic [DATA_W-1:0]  prdata
);

  localparam int unsigned     IDX_W      = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [ADDR_W:0] REGION_END = (ADDR_W+1)'(NUM_SLV) << REGION_SHIFT;

  typedef enum logic [3:0] {
    S_IDLE, S_W_WAIT, S_W_SETUP, S_W_ENABLE,
    S_R_SETUP, S_R_ENABLE, S_R_DONE, S_ERR1, S_ERR2
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx_q, idx_nxt, dec_idx;
  logic [ADDR_W-1:0] offset;
  logic              valid, mapped, take;

  // Burst and size are deliberately ignored: every beat is a full-word single access.
  logic unused_inputs;
  assign unused_inputs = ^{hburst, hsize, htrans[0]};

  // Address decode of the address-phase inputs.
  assign valid   = hreadyin & htrans[1];
  assign offset  = haddr - BASE_ADDR;
  assign mapped  = (haddr >= BASE_ADDR) && ({1'b0, offset} < REGION_END);
  assign dec_idx = IDX_W'(offset >> REGION_SHIFT);

  // Next-state logic; states not listed are the hreadyout=1 accept states.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    take      = 1'b0;
    case (state)
      S_W_WAIT:   state_nxt = S_W_SETUP;
      S_W_SETUP:  state_nxt = S_W_ENABLE;
      S_R_SETUP:  state_nxt = S_R_ENABLE;
      S_R_ENABLE: state_nxt = S_R_DONE;
      S_ERR1:     state_nxt = S_ERR2;
      default: begin
        if (valid) begin
          take    = 1'b1;
          idx_nxt = dec_idx;
          if (!mapped)     state_nxt = S_ERR1;
          else if (hwrite) state_nxt = S_W_WAIT;
          else             state_nxt = S_R_SETUP;
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // State, latched transfer attributes and outputs decoded from the next state.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= S_IDLE;
      idx_q     <= '0;
      hreadyout <= 1'b1;
      hresp     <= 2'b00;
      hrdata    <= '0;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      pselx     <= '0;
      penable   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx_q <= idx_nxt;
      if (take) begin
        paddr  <= haddr;
        pwrite <= hwrite;
      end
      if (state == S_W_WAIT)   pwdata <= hwdata;
      if (state == S_R_ENABLE) hrdata <= prdata;
      hreadyout <= state_nxt inside {S_IDLE, S_W_ENABLE, S_R_DONE, S_ERR2};
      hresp     <= (state_nxt inside {S_ERR1, S_ERR2}) ? 2'b01 : 2'b00;
      penable   <= state_nxt inside {S_W_ENABLE, S_R_ENABLE};
      pselx     <= (state_nxt inside {S_W_SETUP, S_W_ENABLE, S_R_SETUP, S_R_ENABLE})
                   ? (NUM_SLV'(1) << idx_nxt) : '0;
    end
  end

endmodule
